sram_arbiter: RTL and testbench

- Single owner of the 16-bit external SRAM (1M x 16, 20-bit address).
- Shares the SRAM between the recorder (write requester) and the playback DSP (read requester) using a req/gnt handshake.
- Generates all SRAM control strobes with programmable wait states, and tracks the recorded length so the top controller can bound playback.

---
 rtl/sram_arbiter_pkg.sv | 11 +
 rtl/sram_arbiter_if.sv | 27 ++
 rtl/sram_rr_arbiter.sv | 57 +++++
 rtl/sram_arbiter.sv | 148 ++++++++++++++
 tb/tb_sram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared widths, FSM states and requester ids for the SRAM arbiter
package sram_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {IDLE, RD, WR, WR_RECOV} arb_state_t;

  typedef enum logic {REQ_REC, REQ_PLAY} requester_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - recorder/playback req/gnt bus between the requesters and the SRAM arbiter
interface sram_arbiter_if;

  logic                          i_rec_req;
  logic [sram_pkg::SRAM_AW-1:0]  i_rec_addr;
  logic [sram_pkg::SRAM_DW-1:0]  i_rec_data;
  logic                          o_rec_gnt;
  logic                          i_play_req;
  logic [sram_pkg::SRAM_AW-1:0]  i_play_addr;
  logic                          o_play_gnt;
  logic [sram_pkg::SRAM_DW-1:0]  o_play_data;
  logic                          o_play_valid;
  logic                          i_clear;
  logic [sram_pkg::SRAM_AW:0]    o_rec_len;
  logic                          o_busy;

  modport master (
    output i_rec_req, i_rec_addr, i_rec_data, i_play_req, i_play_addr, i_clear,
    input  o_rec_gnt, o_play_gnt, o_play_data, o_play_valid, o_rec_len, o_busy
  );

  modport slave (
    input  i_rec_req, i_rec_addr, i_rec_data, i_play_req, i_play_addr, i_clear,
    output o_rec_gnt, o_play_gnt, o_play_data, o_play_valid, o_rec_len, o_busy
  );

endinterface

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-input grant logic; round-robin, or fixed playback priority with SRAM_ARB_PLAY_PRIO_EN
module sram_rr_arbiter
  import sram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rec_req,
  input  logic play_req,
  output logic rec_gnt,
  output logic play_gnt
);

`ifdef SRAM_ARB_PLAY_PRIO_EN

  logic unused_clk_rst;
  assign unused_clk_rst = clk | rst;

  always_comb begin
    play_gnt = en && play_req;
    rec_gnt  = en && rec_req && !play_req;
  end

`else

  requester_t last_grant_q, last_grant_d;

  // On a conflict the requester that did not win last time is served.
  always_comb begin
    rec_gnt      = 1'b0;
    play_gnt     = 1'b0;
    last_grant_d = last_grant_q;
    if (en) begin
      if (play_req && (!rec_req || last_grant_q == REQ_REC)) begin
        play_gnt = 1'b1;
      end else if (rec_req) begin
        rec_gnt = 1'b1;
      end
      if (play_gnt) begin
        last_grant_d = REQ_PLAY;
      end else if (rec_gnt) begin
        last_grant_d = REQ_REC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_REC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - sole owner of the 1Mx16 SRAM: arbitration, wait-stated strobes, recorded length
// Optional fixed playback priority: define SRAM_ARB_PLAY_PRIO_EN.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_arbiter_if.slave      bus,
  output logic [SRAM_AW-1:0] o_SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
  output logic               o_SRAM_CE_N,
  output logic               o_SRAM_OE_N,
  output logic               o_SRAM_WE_N,
  output logic               o_SRAM_LB_N,
  output logic               o_SRAM_UB_N
);

  localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT - 1);

  arb_state_t         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [SRAM_DW-1:0] wdata_q, wdata_d;
  logic [SRAM_DW-1:0] pdata_q, pdata_d;
  logic               pvalid_q, pvalid_d;
  logic [SRAM_AW:0]   len_q, len_d, len_inc;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic               idle, rec_gnt, play_gnt;

  assign idle = (state_q == IDLE);

  sram_rr_arbiter u_arb (
    .clk      (i_clk),
    .rst      (i_rst),
    .en       (idle),
    .rec_req  (bus.i_rec_req),
    .play_req (bus.i_play_req),
    .rec_gnt  (rec_gnt),
    .play_gnt (play_gnt)
  );

  assign len_inc = {1'b0, bus.i_rec_addr} + 21'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pdata_d  = pdata_q;
    pvalid_d = 1'b0;
    len_d    = len_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (play_gnt) begin
          addr_d  = bus.i_play_addr;
          state_d = RD;
        end else if (rec_gnt) begin
          addr_d  = bus.i_rec_addr;
          wdata_d = bus.i_rec_data;
          state_d = WR;
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          pdata_d  = io_SRAM_DQ;
          pvalid_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR: begin
        if (cnt_q == WR_LAST) begin
          state_d = WR_RECOV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_RECOV: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Clear beats a coincident write grant.
    if (bus.i_clear) begin
      len_d = '0;
    end else if (rec_gnt && (len_inc > len_q)) begin
      len_d = len_inc;
    end

    // Strobes are decoded from the next state so they are glitch-free flop outputs.
    ce_n_d  = (state_d == IDLE);
    oe_n_d  = (state_d != RD);
    we_n_d  = (state_d != WR);
    dq_oe_d = (state_d == WR) || (state_d == WR_RECOV);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      len_q    <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      pdata_q  <= pdata_d;
      pvalid_q <= pvalid_d;
      len_q    <= len_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  assign bus.o_rec_gnt    = rec_gnt;
  assign bus.o_play_gnt   = play_gnt;
  assign bus.o_play_data  = pdata_q;
  assign bus.o_play_valid = pvalid_q;
  assign bus.o_rec_len    = len_q;
  assign bus.o_busy       = !idle;

  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_LB_N = ce_n_q;
  assign o_SRAM_UB_N = ce_n_q;
  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM model and reference scoreboard
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int READ_WAIT  = 2;
  localparam int WRITE_WAIT = 2;
`ifdef SRAM_ARB_PLAY_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();
  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  sram_arbiter #(.READ_WAIT(READ_WAIT), .WRITE_WAIT(WRITE_WAIT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (sram_dq),
    .o_SRAM_CE_N (ce_n),
    .o_SRAM_OE_N (oe_n),
    .o_SRAM_WE_N (we_n),
    .o_SRAM_LB_N (lb_n),
    .o_SRAM_UB_N (ub_n)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(logic [19:0] a);
    logic [15:0] w;
    if (a == 20'h00010) return 16'h1234;
    w = a[15:0] * 16'h9E37;
    return w ^ {a[19:16], 12'hA5A};
  endfunction

  // SRAM device model: full 20-bit address space, unwritten words follow init_word
  logic [15:0] sram_mem [int];
  logic [15:0] rd_word;
  always @(posedge clk) if (!ce_n && !we_n) sram_mem[int'(sram_addr)] = sram_dq;
  always @(negedge clk)
    rd_word = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : init_word(sram_addr);
  assign sram_dq = (!ce_n && !oe_n && we_n) ? rd_word : 16'hzzzz;

  // Reference: memory image, queue of expected read words, expected recorded length
  logic [15:0] ref_mem [int];
  logic [15:0] exp_q [$];
  logic [20:0] exp_len = '0;
  bit          rec_g, play_g;

  function automatic logic [15:0] ref_word(logic [19:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
  endfunction

  always @(negedge clk) begin
    rec_g  = 1'b0;
    play_g = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_len = '0;
    end else begin
      rec_g  = bus.o_rec_gnt;
      play_g = bus.o_play_gnt;
      if (rec_g || play_g) begin
        check("one_gnt", 32'(rec_g && play_g), 32'd0);
        check("gnt_only_idle", 32'(bus.o_busy), 32'd0);
      end
      if (bus.o_play_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got valid=1 expected no pending read at %0t", $time);
        end else begin
          check("read_data", 32'(bus.o_play_data), 32'(exp_q.pop_front()));
        end
      end
      check("rec_len", 32'(bus.o_rec_len), 32'(exp_len));
      if (rec_g) begin
        ref_mem[int'(bus.i_rec_addr)] = bus.i_rec_data;
        if (!bus.i_clear && ({1'b0, bus.i_rec_addr} + 21'd1 > exp_len))
          exp_len = {1'b0, bus.i_rec_addr} + 21'd1;
      end
      if (bus.i_clear) exp_len = '0;
      if (play_g) exp_q.push_back(ref_word(bus.i_play_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_rec_req = 0; bus.i_rec_addr = '0; bus.i_rec_data = '0;
    bus.i_play_req = 0; bus.i_play_addr = '0; bus.i_clear = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    check("rst_outputs", {9'd0, bus.o_play_valid, bus.o_rec_gnt, bus.o_play_gnt, bus.o_busy, 3'd0, bus.o_play_data},
          32'd0);
    check("rst_len_addr", {11'd0, bus.o_rec_len} | {12'd0, sram_addr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!bus.o_busy) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=1 expected idle within 64 cycles");
    end
  endtask

  typedef struct {
    bit rec;
    bit play;
    bit exp_rec;
    bit exp_play;
  } arb_vec_t;

  arb_vec_t tbl [8];

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, last_c;
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{1, 1, !PRIO, PRIO};
    tbl[3] = '{0, 1, 0, 1};
    tbl[4] = '{0, 1, 0, 1};
    tbl[5] = '{1, 1, !PRIO, PRIO};
    tbl[6] = '{1, 0, 1, 0};
    tbl[7] = '{1, 1, 0, 1};

    do_reset();

    // Single read of 0x00010
    step(); bus.i_play_req = 1; bus.i_play_addr = 20'h00010;
    @(negedge clk); check("rd_gnt", {30'd0, bus.o_play_gnt, bus.o_rec_gnt}, 32'h2);
    step(); bus.i_play_req = 0; bus.i_play_addr = 20'h55555;
    @(negedge clk); check("rd_c1", {11'd0, oe_n, ce_n, sram_addr}, 32'h00010);
    check("rd_c1_valid", 32'(bus.o_play_valid), 32'd0);
    step(); @(negedge clk); check("rd_c2", {30'd0, oe_n, bus.o_play_valid}, 32'd0);
    step(); @(negedge clk); check("rd_c3", {14'd0, oe_n, bus.o_play_valid, bus.o_play_data}, 32'h31234);
    step(); @(negedge clk); check("rd_c4", {15'd0, bus.o_play_valid, bus.o_play_data}, 32'h01234);

    // Write 0xBEEF to 0x0ABCD, then read it back
    step(); bus.i_rec_req = 1; bus.i_rec_addr = 20'h0ABCD; bus.i_rec_data = 16'hBEEF;
    @(negedge clk); check("wr_gnt", {30'd0, bus.o_play_gnt, bus.o_rec_gnt}, 32'h1);
    step(); bus.i_rec_req = 0; bus.i_rec_addr = '0; bus.i_rec_data = '0;
    @(negedge clk); check("wr_c1", {29'd0, we_n, oe_n, ce_n}, 32'h2);
    check("wr_len", 32'(bus.o_rec_len), 32'h0ABCE);
    step(); @(negedge clk); check("wr_c2", {29'd0, we_n, oe_n, ce_n}, 32'h2);
    step(); @(negedge clk); check("wr_recov", {29'd0, we_n, ce_n, bus.o_busy}, 32'h5);
    step(); @(negedge clk); check("wr_idle", {30'd0, ce_n, bus.o_busy}, 32'h2);
    step(); bus.i_play_req = 1; bus.i_play_addr = 20'h0ABCD;
    @(negedge clk); check("rb_gnt", 32'(bus.o_play_gnt), 32'd1);
    step(); bus.i_play_req = 0;
    step(); step(); @(negedge clk);
    check("rb_data", {15'd0, bus.o_play_valid, bus.o_play_data}, 32'h1BEEF);

    // Table of one-shot arbitration decisions from a fresh last_grant
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      bus.i_rec_req = tbl[i].rec; bus.i_play_req = tbl[i].play;
      bus.i_rec_addr = 20'h00200 + 20'(i); bus.i_rec_data = 16'($urandom);
      bus.i_play_addr = 20'($urandom);
      @(negedge clk);
      check($sformatf("arb_vec%0d", i), {30'd0, bus.o_rec_gnt, bus.o_play_gnt},
            {30'd0, tbl[i].exp_rec, tbl[i].exp_play});
      step(); bus.i_rec_req = 0; bus.i_play_req = 0;
      wait_idle();
    end

    // Both requests held continuously for 20 grants
    do_reset();
    step();
    bus.i_rec_req = 1; bus.i_play_req = 1;
    bus.i_rec_addr = 20'($urandom); bus.i_rec_data = 16'($urandom); bus.i_play_addr = 20'($urandom);
    n = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      @(negedge clk);
      if (bus.o_rec_gnt || bus.o_play_gnt) begin
        check($sformatf("hold_gnt%0d", n), 32'(bus.o_play_gnt), PRIO ? 32'd1 : 32'((n % 2) == 0));
        n++;
        step();
        bus.i_rec_addr = 20'($urandom); bus.i_rec_data = 16'($urandom); bus.i_play_addr = 20'($urandom);
      end else begin
        step();
      end
    end
    check("hold_count", n, 20);
    bus.i_play_req = 0;
    wait_idle();
    check("rec_after_play_drop", {30'd0, bus.o_rec_gnt, bus.o_play_gnt}, 32'h2);
    step(); bus.i_rec_req = 0;
    wait_idle();

    // Back-to-back reads: one grant every READ_WAIT+1 cycles
    step(); bus.i_play_req = 1; n = 0; last_c = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.o_play_gnt) begin
        if (n > 0) check("rd_throughput", c - last_c, READ_WAIT + 1);
        last_c = c;
        n++;
        step(); bus.i_play_addr = 20'($urandom);
      end else begin
        step();
      end
    end
    check("rd_tp_count", n, 4);
    bus.i_play_req = 0;
    wait_idle();

    // rec_len top boundary and clear coinciding with a write grant
    step(); bus.i_rec_req = 1; bus.i_rec_addr = 20'hFFFFF; bus.i_rec_data = 16'h0F0F;
    @(negedge clk); check("top_gnt", 32'(bus.o_rec_gnt), 32'd1);
    step(); bus.i_rec_req = 0;
    @(negedge clk); check("len_top", 32'(bus.o_rec_len), 32'h100000);
    wait_idle();
    step(); bus.i_rec_req = 1; bus.i_rec_addr = 20'h00005; bus.i_clear = 1;
    @(negedge clk); check("clr_gnt", 32'(bus.o_rec_gnt), 32'd1);
    step(); bus.i_rec_req = 0; bus.i_clear = 0;
    @(negedge clk); check("len_cleared", 32'(bus.o_rec_len), 32'd0);
    check("clr_write_runs", 32'(we_n), 32'd0);
    repeat (5) begin step(); @(negedge clk); end
    check("len_stays_0", 32'(bus.o_rec_len), 32'd0);
    wait_idle();

    // Asynchronous reset in the middle of a write
    step(); bus.i_rec_req = 1; bus.i_rec_addr = 20'h00321; bus.i_rec_data = ref_word(20'h00321);
    @(negedge clk); check("mid_gnt", 32'(bus.o_rec_gnt), 32'd1);
    step(); bus.i_rec_req = 0;
    @(negedge clk); check("mid_in_wr", 32'(we_n), 32'd0);
    @(posedge clk); #3 rst = 1'b1;
    #1 check("async_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    check("async_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin @(negedge clk); check("no_valid_after_rst", 32'(bus.o_play_valid), 32'd0); step(); end
    bus.i_rec_req = 1; bus.i_play_req = 1;
    @(negedge clk); check("first_conflict", {30'd0, bus.o_rec_gnt, bus.o_play_gnt}, 32'h1);
    step(); bus.i_rec_req = 0; bus.i_play_req = 0;
    wait_idle();

    // Randomised traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      step();
      if (!bus.i_rec_req || rec_g) begin
        bus.i_rec_req = ($urandom_range(2) == 0);
        bus.i_rec_addr = 20'($urandom); bus.i_rec_data = 16'($urandom);
      end else if ($urandom_range(15) == 0) begin
        bus.i_rec_req = 0;
      end
      if (!bus.i_play_req || play_g) begin
        bus.i_play_req = ($urandom_range(2) == 0);
        bus.i_play_addr = ($urandom_range(1) == 0) ? 20'($urandom) : 20'($urandom_range(15) + 32'h0ABC0);
      end else if ($urandom_range(15) == 0) begin
        bus.i_play_req = 0;
      end
      bus.i_clear = ($urandom_range(30) == 0);
    end
    step(); bus.i_rec_req = 0; bus.i_play_req = 0; bus.i_clear = 0;
    wait_idle();
    repeat (3) step();
    check("pending_reads", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
